jesd204b_rx_link_ctrl: RTL

//  Multi-link JESD204B receiver control: one independent FSM per link sequences
//  GT reset, PHY wait, CGS, LMFC-aligned SYNC release and data monitoring.

---
 rtl/jesd204b_rx_link_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/jesd204b_rx_link_ctrl.sv
// JESD204B receiver link control: one sequencing FSM per link (GT reset, PHY wait,
// CGS, LMFC-aligned SYNC release, data monitoring with windowed error-rate resync).
module jesd204b_rx_link_ctrl #(
    parameter int L                 = 4,
    parameter int LINKS             = 1,
    parameter int PARALLEL_OCTETS   = 4,
    parameter int RST_GT_CYCLES     = 4,
    parameter int CGS_STABLE_CYCLES = 16,
    parameter int ERR_WIN_W         = 16,
    parameter int ERR_CTR_W         = 12
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [L-1:0]                    lane_disable_i,
    input  logic [LINKS-1:0]                link_disable_i,
    input  logic [LINKS-1:0]                gtx_ready_i,
    input  logic [L-1:0]                    cgs_detected_i,
    input  logic                            lmfc_clk_i,
    input  logic [L*PARALLEL_OCTETS-1:0]    gtx_notintable_i,
    input  logic [L*PARALLEL_OCTETS-1:0]    gtx_disperr_i,
    input  logic [LINKS-1:0]                resync_req_i,
    input  logic [ERR_CTR_W-1:0]            err_thresh_i,
    output logic [LINKS-1:0]                rx_reset_gt_o,
    output logic [LINKS-1:0]                gtx_en_char_align_o,
    output logic [L-1:0]                    cgs_rst_o,
    output logic [L-1:0]                    ifs_rst_o,
    output logic [LINKS-1:0]                sync_o,
    output logic [LINKS-1:0]                latency_monitor_rst_n_o,
    output logic [LINKS-1:0]                link_up_o,
    output logic [3*LINKS-1:0]              link_state_o,
    output logic [8*LINKS-1:0]              resync_cnt_o
);

    localparam int LPL     = L / LINKS;
    localparam int OPL     = LPL * PARALLEL_OCTETS;
    localparam int CNT_MAX = (RST_GT_CYCLES > CGS_STABLE_CYCLES) ? RST_GT_CYCLES : CGS_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_WAIT_PHY  = 3'd1;
    localparam logic [2:0] ST_CGS       = 3'd2;
    localparam logic [2:0] ST_WAIT_LMFC = 3'd3;
    localparam logic [2:0] ST_DATA      = 3'd4;

    if ((L % LINKS) != 0) begin : g_bad_cfg
        $error("jesd204b_rx_link_ctrl: L must be a multiple of LINKS");
    end

    for (genvar gi = 0; gi < LINKS; gi++) begin : g_link
        logic [2:0]           state_q, state_d;
        logic [CNT_W-1:0]     cnt_q, cnt_d;
        logic [ERR_WIN_W-1:0] win_q, win_d;
        logic [ERR_CTR_W-1:0] err_q, err_d, err_inc;
        logic [7:0]           rcnt_q, rcnt_d;
        logic                 rst_gt_q, rst_gt_d, align_q, align_d, sync_q, sync_d;
        logic                 lat_q, lat_d, up_q, up_d;
        logic [LPL-1:0]       cgs_rst_q, cgs_rst_d, ifs_rst_q, ifs_rst_d;
        logic [LPL-1:0]       ldis;
        logic [OPL-1:0]       oct_en, oct_err;
        logic                 cgs_ok, err_cycle, trip;

        assign ldis = lane_disable_i[gi*LPL +: LPL];
        // A link whose lanes are all disabled must never pass CGS.
        assign cgs_ok = (&(cgs_detected_i[gi*LPL +: LPL] | ldis)) && !(&ldis);

        for (genvar gj = 0; gj < LPL; gj++) begin : g_oct_en
            assign oct_en[gj*PARALLEL_OCTETS +: PARALLEL_OCTETS] = {PARALLEL_OCTETS{~ldis[gj]}};
        end

        assign oct_err   = (gtx_notintable_i[gi*OPL +: OPL] | gtx_disperr_i[gi*OPL +: OPL]) & oct_en;
        assign err_cycle = |oct_err;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            win_d   = '0;
            err_d   = '0;
            err_inc = err_q;
            rcnt_d  = rcnt_q;
            trip    = 1'b0;
            case (state_q)
                ST_RESET: begin
                    if (link_disable_i[gi]) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(RST_GT_CYCLES - 1)) begin
                        state_d = ST_WAIT_PHY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_PHY: begin
                    cnt_d = '0;
                    if (gtx_ready_i[gi]) state_d = ST_CGS;
                end
                ST_CGS: begin
                    if (!cgs_ok) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(CGS_STABLE_CYCLES - 1)) begin
                        state_d = ST_WAIT_LMFC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LMFC: begin
                    if (lmfc_clk_i) state_d = ST_DATA;
                end
                ST_DATA: begin
                    err_inc = (err_cycle && (err_q != {ERR_CTR_W{1'b1}})) ? err_q + 1'b1 : err_q;
                    trip    = (err_thresh_i != '0) && (err_inc >= err_thresh_i);
                    win_d   = win_q + 1'b1;
                    // The cycle on which the window wraps still counts toward a trip.
                    err_d   = (&win_q) ? '0 : err_inc;
                end
                default: state_d = ST_RESET;
            endcase

            if (state_q != ST_RESET) begin
                if (link_disable_i[gi]) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end else if (resync_req_i[gi] || trip) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
                end
            end
        end

        always_comb begin
            rst_gt_d  = (state_d == ST_RESET);
            align_d   = (state_d == ST_CGS);
            sync_d    = !((state_d == ST_CGS) || (state_d == ST_WAIT_LMFC));
            lat_d     = (state_d == ST_DATA);
            up_d      = (state_d == ST_DATA);
            cgs_rst_d = ((state_d == ST_RESET) || (state_d == ST_WAIT_PHY)) ? {LPL{1'b1}} : ldis;
            ifs_rst_d = (state_d == ST_DATA) ? ldis : {LPL{1'b1}};
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q   <= ST_RESET;
                cnt_q     <= '0;
                win_q     <= '0;
                err_q     <= '0;
                rcnt_q    <= '0;
                rst_gt_q  <= 1'b1;
                align_q   <= 1'b0;
                sync_q    <= 1'b1;
                lat_q     <= 1'b0;
                up_q      <= 1'b0;
                cgs_rst_q <= {LPL{1'b1}};
                ifs_rst_q <= {LPL{1'b1}};
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                win_q     <= win_d;
                err_q     <= err_d;
                rcnt_q    <= rcnt_d;
                rst_gt_q  <= rst_gt_d;
                align_q   <= align_d;
                sync_q    <= sync_d;
                lat_q     <= lat_d;
                up_q      <= up_d;
                cgs_rst_q <= cgs_rst_d;
                ifs_rst_q <= ifs_rst_d;
            end
        end

        assign rx_reset_gt_o[gi]              = rst_gt_q;
        assign gtx_en_char_align_o[gi]        = align_q;
        assign sync_o[gi]                     = sync_q;
        assign latency_monitor_rst_n_o[gi]    = lat_q;
        assign link_up_o[gi]                  = up_q;
        assign cgs_rst_o[gi*LPL +: LPL]       = cgs_rst_q;
        assign ifs_rst_o[gi*LPL +: LPL]       = ifs_rst_q;
        assign link_state_o[gi*3 +: 3]        = state_q;
        assign resync_cnt_o[gi*8 +: 8]        = rcnt_q;
    end

endmodule
